// File: rtl/ifetch_multi.sv
// ---------------------------------------------------------------------------
// ifetch_multi -- instruction fetch stage with prioritised redirects and a
// multi-issue fetch queue.
//
// The PC register produces an 8-byte-aligned Icache request. Each accepted
// 64-bit fill pushes one or two 32-bit instructions into a circular fetch
// queue. A fill at PC[2]=0 pushes both words. A fill at PC[2]=1 pushes only
// the upper word. Up to DEQ_WIDTH instructions are shown from the queue
// head and can be consumed in the same cycle. A redirect loads a new PC and
// flushes the queue. Redirect channel 0 has the highest priority.
//
// Ports:
//   clock                   in   rising-edge clock
//   reset                   in   asynchronous, active-low reset
//   if_valid                in   fetch enable
//   redir_req               in   [NUM_REDIR]          redirect requests
//   redir_pc                in   [NUM_REDIR*XLEN]     redirect targets
//   proc2Icache_addr        out  [XLEN]               aligned fetch address
//   proc2Icache_req         out                       fetch request
//   Icache2proc_data        in   [64]                 returned line
//   Icache2proc_data_valid  in                        line valid
//   out_valid               out  [DEQ_WIDTH]          head slot valid
//   out_inst                out  [DEQ_WIDTH*32]       head instructions
//   out_pc                  out  [DEQ_WIDTH*XLEN]     head PCs
//   deq_count               in   [clog2(DEQ_WIDTH+1)] slots consumed
//   fq_count                out  [clog2(FQ_DEPTH+1)]  queue occupancy
//
// Optional feature: define IFETCH_DEBUG_EN to add these two outputs:
//   gnt_debug  out [NUM_REDIR]  one-hot grant for the winning redirect
//   fill_cnt   out [32]         saturating count of accepted fills
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module ifetch_multi #(
  parameter int NUM_REDIR = 3,
  parameter int FQ_DEPTH  = 8,
  parameter int DEQ_WIDTH = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           if_valid,
  input  logic [NUM_REDIR-1:0]           redir_req,
  input  logic [NUM_REDIR*`XLEN-1:0]     redir_pc,
  output logic [`XLEN-1:0]               proc2Icache_addr,
  output logic                           proc2Icache_req,
  input  logic [63:0]                    Icache2proc_data,
  input  logic                           Icache2proc_data_valid,
  output logic [DEQ_WIDTH-1:0]           out_valid,
  output logic [DEQ_WIDTH*32-1:0]        out_inst,
  output logic [DEQ_WIDTH*`XLEN-1:0]     out_pc,
  input  logic [$clog2(DEQ_WIDTH+1)-1:0] deq_count,
  output logic [$clog2(FQ_DEPTH+1)-1:0]  fq_count
`ifdef IFETCH_DEBUG_EN
  ,
  output logic [NUM_REDIR-1:0]           gnt_debug,
  output logic [31:0]                    fill_cnt
`endif
);

  localparam int XL = `XLEN;
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = $clog2(FQ_DEPTH+1);

  // Fetch queue storage and control
  logic [31:0]    r_fq_inst [FQ_DEPTH];
  logic [XL-1:0]  r_fq_pc   [FQ_DEPTH];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic [XL-1:0]  r_pc;

  logic           w_redir_any;
  logic [XL-1:0]  w_target;
  logic [XL-1:0]  w_line_addr;
  logic [CW-1:0]  w_free;
  logic           w_req;
  logic           w_fill;
  logic [CW-1:0]  w_enq;
  logic [CW-1:0]  w_deq;
  logic [PW-1:0]  w_tail_p1;

  // Redirect arbitration. The loop runs from the highest index down to
  // index 0, so the lowest-index requester writes last and wins.
  // NOTE: every signal assigned in always_comb gets a default value first.
  // Without the default, a path that assigns nothing would infer a latch.
  always_comb begin
    w_target = '0;
    for (int i = NUM_REDIR-1; i >= 0; i--) begin
      if (redir_req[i]) w_target = redir_pc[i*XL +: XL];
    end
  end

  assign w_redir_any = |redir_req;
  assign w_line_addr = {r_pc[XL-1:3], 3'b000};
  assign w_free      = CW'(FQ_DEPTH) - r_count;

  // A fill can push up to two words, so a request needs two free entries.
  // While reset is held low, the request is forced off.
  assign w_req  = reset && if_valid && (w_free >= CW'(2)) && !w_redir_any;
  assign w_fill = w_req && Icache2proc_data_valid;
  assign w_enq  = w_fill ? (r_pc[2] ? CW'(1) : CW'(2)) : '0;

  // Clamp the consumer's dequeue count to the number of valid entries.
  assign w_deq     = (CW'(deq_count) > r_count) ? r_count : CW'(deq_count);
  assign w_tail_p1 = r_tail + PW'(1);

  assign proc2Icache_addr = w_line_addr;
  assign proc2Icache_req  = w_req;
  assign fq_count         = r_count;

  // NOTE: sequential state uses non-blocking assignments. All registers then
  // update together at the edge, whatever order the statements are in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc    <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_redir_any) begin
      // A redirect wins over a fill or dequeue in the same cycle.
      r_pc    <= {w_target[XL-1:2], 2'b00};
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_fill) r_pc <= w_line_addr + XL'(8);
      r_head  <= r_head + PW'(w_deq);
      r_tail  <= r_tail + PW'(w_enq);
      r_count <= r_count + w_enq - w_deq;
    end
  end

  // NOTE: the queue storage has no reset. Entries are never read unless
  // r_count marks them valid, so resetting the array would buy nothing.
  always_ff @(posedge clock) begin
    if (w_fill) begin
      if (r_pc[2]) begin
        r_fq_inst[r_tail] <= Icache2proc_data[63:32];
        r_fq_pc[r_tail]   <= r_pc;
      end else begin
        r_fq_inst[r_tail]    <= Icache2proc_data[31:0];
        r_fq_pc[r_tail]      <= r_pc;
        r_fq_inst[w_tail_p1] <= Icache2proc_data[63:32];
        r_fq_pc[w_tail_p1]   <= r_pc + XL'(4);
      end
    end
  end

  // The queue head drives the outputs directly. Index arithmetic is
  // PW bits wide, so it wraps with the circular buffer.
  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      out_valid[i]          = (r_count > CW'(i));
      out_inst[i*32 +: 32]  = r_fq_inst[r_head + PW'(i)];
      out_pc[i*XL +: XL]    = r_fq_pc[r_head + PW'(i)];
    end
  end

`ifdef IFETCH_DEBUG_EN
  logic [31:0] r_fill_cnt;

  // x & -x keeps only the lowest set bit, which is the winning channel.
  assign gnt_debug = redir_req & (~redir_req + NUM_REDIR'(1));
  assign fill_cnt  = r_fill_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fill_cnt <= '0;
    end else if (w_fill && (r_fill_cnt != 32'hFFFF_FFFF)) begin
      r_fill_cnt <= r_fill_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_multi.sv
// ---------------------------------------------------------------------------
// tb_ifetch_multi -- directed bench for ifetch_multi with default parameters
// (3 redirect channels, 8-entry queue, 2-wide dequeue, 32-bit XLEN).
// A table of single-cycle vectors covers redirect priority, aligned and
// unaligned fills, dequeue clamping and flush. Hand-written sequences cover
// queue-full back-pressure, in-order streaming across pointer wrap, and
// reset asserted in the middle of a request.
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module tb_ifetch_multi;

  logic         clock = 1'b0;
  logic         reset;
  logic         if_valid;
  logic [2:0]   redir_req;
  logic [95:0]  redir_pc;
  logic [31:0]  proc2Icache_addr;
  logic         proc2Icache_req;
  logic [63:0]  Icache2proc_data;
  logic         Icache2proc_data_valid;
  logic [1:0]   out_valid;
  logic [63:0]  out_inst;
  logic [63:0]  out_pc;
  logic [1:0]   deq_count;
  logic [3:0]   fq_count;
`ifdef IFETCH_DEBUG_EN
  logic [2:0]   gnt_debug;
  logic [31:0]  fill_cnt;
`endif

  ifetch_multi dut (
    .clock                  (clock),
    .reset                  (reset),
    .if_valid               (if_valid),
    .redir_req              (redir_req),
    .redir_pc               (redir_pc),
    .proc2Icache_addr       (proc2Icache_addr),
    .proc2Icache_req        (proc2Icache_req),
    .Icache2proc_data       (Icache2proc_data),
    .Icache2proc_data_valid (Icache2proc_data_valid),
    .out_valid              (out_valid),
    .out_inst               (out_inst),
    .out_pc                 (out_pc),
    .deq_count              (deq_count),
    .fq_count               (fq_count)
`ifdef IFETCH_DEBUG_EN
    ,
    .gnt_debug              (gnt_debug),
    .fill_cnt               (fill_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One vector: inputs are applied at the falling edge. The request is
  // checked before the rising edge. The state outputs are checked just
  // after the rising edge.
  typedef struct {
    logic [2:0]  rq;
    logic [95:0] rpc;
    logic        iv;
    logic [63:0] data;
    logic        dv;
    logic [1:0]  deq;
    logic        e_req;
    logic [31:0] e_addr;
    logic [3:0]  e_cnt;
    logic [1:0]  e_ov;
    logic [31:0] e_i0, e_p0, e_i1, e_p1;
  } vec_t;

  vec_t tv [13];

  // Streaming model state
  logic [31:0] m_pc;
  int          m_cnt;
  logic [31:0] m_deq_pc;
  int          n_consumed;

  // Instruction word that the bench's memory holds at a given address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic do_redirect(input int ch, input logic [31:0] target);
    @(negedge clock);
    redir_req = '0;
    redir_req[ch] = 1'b1;
    redir_pc = '0;
    redir_pc[ch*32 +: 32] = target;
    Icache2proc_data_valid = 1'b0;
    deq_count = '0;
    @(posedge clock);
    #1;
    redir_req = '0;
  endtask

  // One streaming cycle. The bench's memory answers every request, and a
  // model of occupancy and order predicts the outputs.
  task automatic stream_cycle(input int deq_val);
    logic [31:0] line;
    logic        e_req;
    int          ndeq;
    @(negedge clock);
    line = {m_pc[31:3], 3'b000};
    redir_req = '0;
    if_valid = 1'b1;
    deq_count = 2'(deq_val);
    Icache2proc_data = {mem_word(line + 32'd4), mem_word(line)};
    Icache2proc_data_valid = 1'b1;
    #2;
    e_req = ((8 - m_cnt) >= 2);
    check("strm_req", 64'(proc2Icache_req), 64'(e_req));
    check("strm_addr", 64'(proc2Icache_addr), 64'(line));
    check("strm_cnt", 64'(fq_count), 64'(m_cnt));
    ndeq = (deq_val > m_cnt) ? m_cnt : deq_val;
    for (int j = 0; j < ndeq; j++) begin
      check("strm_inst", 64'(out_inst[j*32 +: 32]), 64'(mem_word(m_deq_pc)));
      check("strm_pc", 64'(out_pc[j*32 +: 32]), 64'(m_deq_pc));
      m_deq_pc = m_deq_pc + 32'd4;
      n_consumed++;
    end
    m_cnt = m_cnt - ndeq;
    if (e_req) begin
      m_cnt = m_cnt + (m_pc[2] ? 1 : 2);
      m_pc  = line + 32'd8;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Table of single-cycle vectors
    tv[0]  = '{3'b111, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 1'b1, 64'h0, 1'b0, 2'd0,
               1'b0, 32'h1111_1110, 4'd0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0};
    tv[1]  = '{3'b001, {64'h0, 32'h0000_0100}, 1'b1, 64'h0, 1'b0, 2'd0,
               1'b0, 32'h0000_0100, 4'd0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0};
    tv[2]  = '{3'b000, 96'h0, 1'b1, 64'hBBBB_BBBB_AAAA_AAAA, 1'b1, 2'd0,
               1'b1, 32'h0000_0108, 4'd2, 2'b11, 32'hAAAA_AAAA, 32'h100, 32'hBBBB_BBBB, 32'h104};
    tv[3]  = '{3'b100, {32'h0000_0104, 64'h0}, 1'b1, 64'h0, 1'b0, 2'd0,
               1'b0, 32'h0000_0100, 4'd0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0};
    tv[4]  = '{3'b000, 96'h0, 1'b1, 64'h2222_2222_1111_1111, 1'b1, 2'd0,
               1'b1, 32'h0000_0108, 4'd1, 2'b01, 32'h2222_2222, 32'h104, 32'h0, 32'h0};
    tv[5]  = '{3'b000, 96'h0, 1'b1, 64'h4444_4444_3333_3333, 1'b1, 2'd1,
               1'b1, 32'h0000_0110, 4'd2, 2'b11, 32'h3333_3333, 32'h108, 32'h4444_4444, 32'h10C};
    tv[6]  = '{3'b000, 96'h0, 1'b0, 64'h0, 1'b0, 2'd3,
               1'b0, 32'h0000_0110, 4'd0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0};
    tv[7]  = '{3'b000, 96'h0, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 2'd0,
               1'b0, 32'h0000_0110, 4'd0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0};
    tv[8]  = '{3'b000, 96'h0, 1'b1, 64'h6666_6666_5555_5555, 1'b1, 2'd0,
               1'b1, 32'h0000_0118, 4'd2, 2'b11, 32'h5555_5555, 32'h110, 32'h6666_6666, 32'h114};
    tv[9]  = '{3'b010, {32'h0, 32'h0000_2007, 32'h0}, 1'b1, 64'h7777_7777_7777_7777, 1'b1, 2'd2,
               1'b0, 32'h0000_2000, 4'd0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0};
    tv[10] = '{3'b110, {32'h1234_5678, 32'hABCD_0003, 32'h0}, 1'b1, 64'h0, 1'b0, 2'd0,
               1'b0, 32'hABCD_0000, 4'd0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0};
    tv[11] = '{3'b001, {64'h0, 32'hFFFF_FFF8}, 1'b1, 64'h0, 1'b0, 2'd0,
               1'b0, 32'hFFFF_FFF8, 4'd0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0};
    tv[12] = '{3'b000, 96'h0, 1'b1, 64'h8888_8888_7777_7777, 1'b1, 2'd0,
               1'b1, 32'h0000_0000, 4'd2, 2'b11, 32'h7777_7777, 32'hFFFF_FFF8, 32'h8888_8888, 32'hFFFF_FFFC};

    // Reset state, with fetch enabled so that the reset gating of the
    // request is exercised
    reset = 1'b0;
    if_valid = 1'b1;
    redir_req = '0;
    redir_pc = '0;
    Icache2proc_data = '0;
    Icache2proc_data_valid = 1'b0;
    deq_count = '0;
    #2;
    check("rst_req", 64'(proc2Icache_req), 64'd0);
    check("rst_addr", 64'(proc2Icache_addr), 64'd0);
    check("rst_cnt", 64'(fq_count), 64'd0);
    check("rst_ovalid", 64'(out_valid), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int k = 0; k < 13; k++) begin
      @(negedge clock);
      redir_req = tv[k].rq;
      redir_pc = tv[k].rpc;
      if_valid = tv[k].iv;
      Icache2proc_data = tv[k].data;
      Icache2proc_data_valid = tv[k].dv;
      deq_count = tv[k].deq;
      #2;
      check($sformatf("v%0d_req", k), 64'(proc2Icache_req), 64'(tv[k].e_req));
      @(posedge clock);
      #1;
      check($sformatf("v%0d_addr", k), 64'(proc2Icache_addr), 64'(tv[k].e_addr));
      check($sformatf("v%0d_cnt", k), 64'(fq_count), 64'(tv[k].e_cnt));
      check($sformatf("v%0d_ovalid", k), 64'(out_valid), 64'(tv[k].e_ov));
      if (tv[k].e_ov[0]) begin
        check($sformatf("v%0d_inst0", k), 64'(out_inst[31:0]), 64'(tv[k].e_i0));
        check($sformatf("v%0d_pc0", k), 64'(out_pc[31:0]), 64'(tv[k].e_p0));
      end
      if (tv[k].e_ov[1]) begin
        check($sformatf("v%0d_inst1", k), 64'(out_inst[63:32]), 64'(tv[k].e_i1));
        check($sformatf("v%0d_pc1", k), 64'(out_pc[63:32]), 64'(tv[k].e_p1));
      end
    end

    // Back-pressure and wrap. Start at an odd word so that occupancy stops
    // at 7, one below full, where the request must drop. Then drain and
    // stream 3*FQ_DEPTH instructions in order through the wrapping pointers.
    do_redirect(0, 32'h0000_1004);
    m_pc = 32'h0000_1004;
    m_cnt = 0;
    m_deq_pc = 32'h0000_1004;
    n_consumed = 0;
    for (int c = 0; c < 6; c++) stream_cycle(0);
    check("full_cnt", 64'(fq_count), 64'd7);
    check("full_req_low", 64'(proc2Icache_req), 64'd0);
    begin
      int budget;
      budget = 0;
      while (n_consumed < 24 && budget < 100) begin
        stream_cycle((budget % 3 == 2) ? 1 : 2);
        budget++;
      end
      check("wrap_consumed_all", 64'(n_consumed >= 24), 64'd1);
    end

    // Reset in the middle of a request, then a stray beat with no request
    do_redirect(0, 32'h0000_0300);
    @(negedge clock);
    if_valid = 1'b1;
    Icache2proc_data_valid = 1'b0;
    deq_count = '0;
    #2;
    check("midrst_req_before", 64'(proc2Icache_req), 64'd1);
    reset = 1'b0;
    #1;
    check("midrst_req", 64'(proc2Icache_req), 64'd0);
    check("midrst_addr", 64'(proc2Icache_addr), 64'd0);
    check("midrst_cnt", 64'(fq_count), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    if_valid = 1'b0;
    Icache2proc_data = 64'hCAFE_F00D_1234_5678;
    Icache2proc_data_valid = 1'b1;
    #2;
    check("stray_req", 64'(proc2Icache_req), 64'd0);
    @(posedge clock);
    #1;
    check("stray_cnt", 64'(fq_count), 64'd0);
    check("stray_ovalid", 64'(out_valid), 64'd0);
    check("stray_addr", 64'(proc2Icache_addr), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
